rsa_modexp_enc: RTL and testbench

//  Downstream consumer of the key-generation stage: takes the public exponent it produces
//  (public_key), the modulus y and a plaintext word, and computes cipher = msg^e mod n.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_modexp_enc_if.sv | 40 ++++
 rtl/rsa_mod_mult.sv | 74 +++++++
 rtl/rsa_modexp_enc.sv | 169 ++++++++++++++++
 tb/tb_rsa_modexp_enc.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation encrypt slice.
// Holds the default width, the FSM encoding and the multiplier counter width.
package rsa_pkg;

  localparam int RSA_W  = 32;
  localparam int RSA_CW = $clog2(RSA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MUL,
    ST_SQR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rsa_modexp_enc_if.sv
// Request/result bundle between the key stage, the controller and the encryptor.
// The master drives the operands and start; the slave returns the cipher status.
interface rsa_modexp_enc_if
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
);

  logic         start;
  logic [W-1:0] exp_in;
  logic [W-1:0] mod_in;
  logic [W-1:0] msg_in;
  logic [W-1:0] cipher;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start,
    output exp_in,
    output mod_in,
    output msg_in,
    input  cipher,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  exp_in,
    input  mod_in,
    input  msg_in,
    output cipher,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/rsa_mod_mult.sv
// Bit-serial interleaved modular multiplier, MSB first.
// One load cycle plus W iterations; done pulses with p = a*b mod n.
module rsa_mod_mult
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  n_q;
  logic [W+1:0]  acc;
  logic [CW-1:0] cnt;
  logic          run;
  logic          done_q;

  logic [W+1:0] n_ext;
  logic [W+1:0] t0;
  logic [W+1:0] t1;
  logic [W+1:0] t2;

  // acc < n and b < n keep 2*acc + b below 3n, so two subtractions suffice
  always_comb begin
    n_ext = {2'b00, n_q};
    t0    = (acc << 1) + (a_q[W-1] ? {2'b00, b_q} : '0);
    t1    = (t0 >= n_ext) ? t0 - n_ext : t0;
    t2    = (t1 >= n_ext) ? t1 - n_ext : t1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q <= a;
        b_q <= b;
        n_q <= n;
        acc <= '0;
        cnt <= CW'(W);
        run <= 1'b1;
      end else if (run) begin
        acc <= t2;
        a_q <= a_q << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run    <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign p    = acc[W-1:0];

endmodule

// File: rtl/rsa_modexp_enc.sv
// Right-to-left square-and-multiply encryptor: cipher = msg^e mod n.
// Optional operand check enabled by RSA_OPERAND_CHECK_EN.
module rsa_modexp_enc
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic              clk,
  input  logic              rst,
  rsa_modexp_enc_if.slave   bus
);

  state_t state;
  state_t state_d;

  logic [W-1:0] e_q;
  logic [W-1:0] n_q;
  logic [W-1:0] b_q;
  logic [W-1:0] r_q;
  logic [W-1:0] cipher_q;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_p;
  logic         busy_q;
  logic         done_q;
  logic         issued_q;
  logic         fail_q;
  logic         mm_start;
  logic         mm_done;
  logic         chk_fail;
  logic         last_bit;

  assign last_bit = (e_q[W-1:1] == '0);

`ifdef RSA_OPERAND_CHECK_EN
  logic err_q;

  assign chk_fail = (n_q < W'(2)) || (b_q >= n_q);
  assign bus.err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      err_q <= 1'b0;
    end else if (state == ST_DONE) begin
      err_q <= fail_q;
    end
  end
`else
  assign chk_fail = 1'b0;
  assign bus.err  = 1'b0;
`endif

  rsa_mod_mult #(.W(W)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (b_q),
    .n     (n_q),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // the multiplier is launched once on the first cycle of MUL/SQR
  always_comb begin
    state_d  = state;
    mm_start = 1'b0;
    mm_a     = r_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (chk_fail || e_q == '0) state_d = ST_DONE;
        else if (e_q[0])           state_d = ST_MUL;
        else                       state_d = ST_SQR;
      end
      ST_MUL: begin
        mm_start = !issued_q;
        if (mm_done) state_d = ST_SQR;
      end
      ST_SQR: begin
        mm_a = b_q;
        if (last_bit) begin
          state_d = ST_DONE;
        end else begin
          mm_start = !issued_q;
          if (mm_done) state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cipher_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            e_q      <= bus.exp_in;
            n_q      <= bus.mod_in;
            b_q      <= bus.msg_in;
            r_q      <= W'(1);
            busy_q   <= 1'b1;
            issued_q <= 1'b0;
            fail_q   <= 1'b0;
          end
        end
        ST_CHECK: begin
          fail_q <= chk_fail;
          if (e_q == '0) r_q <= (n_q == W'(1)) ? '0 : W'(1);
        end
        ST_MUL: begin
          if (mm_start) issued_q <= 1'b1;
          if (mm_done) begin
            r_q      <= mm_p;
            issued_q <= 1'b0;
          end
        end
        ST_SQR: begin
          if (mm_start) issued_q <= 1'b1;
          if (mm_done) begin
            b_q      <= mm_p;
            e_q      <= e_q >> 1;
            issued_q <= 1'b0;
          end
        end
        ST_DONE: begin
          cipher_q <= fail_q ? '0 : r_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cipher = cipher_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_rsa_modexp_enc.sv
// Self-checking bench for rsa_modexp_enc: vector table, corner sequences
// and randomized operands against an arithmetic reference model.
module tb_rsa_modexp_enc;
  import rsa_pkg::*;

  localparam int W       = 32;
  localparam int LAT_MAX = W * (2 * (W + 2) + 1) + 8;

  logic clk = 1'b0;
  logic rst;

  rsa_modexp_enc_if #(.W(W)) bus ();

  rsa_modexp_enc #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] m;
    logic [31:0] e;
    logic [31:0] n;
    logic [31:0] c;
    int          lat;
  } vec_t;

  function automatic logic [31:0] ref_modexp(
    input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd1 % n;
    b = m % n;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] m, input logic [31:0] e,
                             input logic [31:0] n);
    @(negedge clk);
    bus.msg_in = m;
    bus.exp_in = e;
    bus.mod_in = n;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    while (cyc <= LAT_MAX) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] m,
                        input logic [31:0] e, input logic [31:0] n,
                        input logic [31:0] exp_c, input int exp_lat);
    int cyc;
    bit ok;
    pulse_start(m, e, n);
    check({name, "_busy_hi"}, bus.busy, 1);
    wait_done(cyc, ok);
    check({name, "_done_seen"}, ok, 1);
    check({name, "_cipher"}, bus.cipher, exp_c);
    check({name, "_busy_lo"}, bus.busy, 0);
    check({name, "_no_x"}, $isunknown({bus.cipher, bus.busy, bus.done}), 0);
    if (exp_lat >= 0) check({name, "_latency"}, cyc, exp_lat);
    @(negedge clk);
    check({name, "_one_pulse"}, bus.done, 0);
  endtask

  vec_t vt[8];

  initial begin
    int  cyc;
    bit  ok;
    int  npulse;
    logic [31:0] m;
    logic [31:0] e;
    logic [31:0] n;

    vt[0] = '{32'd4,  32'd13, 32'd497,  32'd445,  -1};
    vt[1] = '{32'd65, 32'd17, 32'd3233, 32'd2790, -1};
    vt[2] = '{32'd7,  32'd0,  32'd11,   32'd1,    3};
    vt[3] = '{32'd7,  32'd1,  32'd11,   32'd7,    -1};
    vt[4] = '{32'd0,  32'd5,  32'd13,   32'd0,    -1};
    vt[5] = '{32'd12, 32'd2,  32'd13,   32'd1,    -1};
    vt[6] = '{32'd3,  32'd4,  32'd7,    32'd4,    -1};
    vt[7] = '{32'd10, 32'd3,  32'd11,   32'd10,   -1};

    bus.start  = 1'b0;
    bus.msg_in = '0;
    bus.exp_in = '0;
    bus.mod_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cipher", bus.cipher, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].m, vt[i].e, vt[i].n,
             vt[i].c, vt[i].lat);
    end

    // start pulses while busy must not spawn a second operation
    pulse_start(32'd65, 32'd17, 32'd3233);
    repeat (10) @(negedge clk);
    bus.msg_in = 32'd7;
    bus.exp_in = 32'd0;
    bus.mod_in = 32'd11;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    check("ign_cipher_mid", bus.cipher, 32'd10);
    wait_done(cyc, ok);
    check("ign_done_seen", ok, 1);
    check("ign_cipher", bus.cipher, 32'd2790);
    npulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) npulse++;
    end
    check("ign_extra_pulses", npulse, 0);
    check("ign_busy", bus.busy, 0);

    // reset in the middle of the first multiply
    pulse_start(32'd65, 32'd17, 32'd3233);
    repeat (8) @(negedge clk);
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cipher", bus.cipher, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'd65, 32'd17, 32'd3233, 32'd2790, -1);

`ifdef RSA_OPERAND_CHECK_EN
    pulse_start(32'd0, 32'd5, 32'd1);
    wait_done(cyc, ok);
    check("chk_n1_done", ok, 1);
    check("chk_n1_err", bus.err, 1);
    check("chk_n1_cipher", bus.cipher, 0);
    @(negedge clk);
    check("chk_n1_err_held", bus.err, 1);
    pulse_start(32'd20, 32'd3, 32'd11);
    wait_done(cyc, ok);
    check("chk_big_m_done", ok, 1);
    check("chk_big_m_err", bus.err, 1);
    run_op("chk_clear", 32'd4, 32'd13, 32'd497, 32'd445, -1);
    check("chk_clear_err", bus.err, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      n = $urandom;
      if (n < 32'd2) n = 32'd3;
      if (i % 3 == 0) n = n | 32'h8000_0001;
      m = $urandom % n;
      e = (i % 4 == 0) ? 32'($urandom_range(0, 16)) : $urandom;
      if (i == 1) e = 32'hFFFF_FFFF;
      run_op($sformatf("rnd%0d", i), m, e, n, ref_modexp(m, e, n), -1);
      check($sformatf("rnd%0d_err", i), bus.err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
